// File: rtl/sparse_pkg.sv
// Shared types for the sparse-matrix word memory, its loader and the multiplier control.
// Pure definitions: no logic, no latency.
package sparse_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        PAYLOAD,
        CHECK,
        DONE,
        ERR
    } loader_state_t;

    // Address increment that wraps at the end of the memory.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a,
                                                   input int unsigned     entries);
        return (a == ADDR_W'(entries - 1)) ? '0 : a + 1'b1;
    endfunction

endpackage

// File: rtl/csr_loader_if.sv
// Byte-stream input and memory write port of the csr loader.
// master = loader side, slave = feeder/memory side.
interface csr_loader_if;
    import sparse_pkg::*;

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              wen;
    logic [ADDR_W-1:0] writePtr;
    logic [DATA_W-1:0] inData;

    modport master (
        input  s_valid, s_data,
        output s_ready, wen, writePtr, inData
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, wen, writePtr, inData
    );

endinterface

// File: rtl/csr_addr_gen.sv
// Byte/word counters and wrapped word address for the loader.
// ptr/word_idx update one cycle after advance; word_complete is combinational; no backpressure.
module csr_addr_gen
    import sparse_pkg::*;
#(
    parameter int ENTRIES        = 64,
    parameter int BASE_ADDR      = 0,
    parameter int BYTES_PER_WORD = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] ptr,
    output logic [ADDR_W-1:0] word_idx,
    output logic              word_complete
);

    localparam int              BC_W = $clog2(BYTES_PER_WORD + 1);
    localparam logic [BC_W-1:0] LAST = BC_W'(BYTES_PER_WORD - 1);

    logic [BC_W-1:0] byte_cnt;

    assign word_complete = advance && (byte_cnt == LAST);

    // ptr tracks (BASE_ADDR + word_idx) mod ENTRIES incrementally, avoiding a divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
            word_idx <= '0;
            ptr      <= ADDR_W'(BASE_ADDR);
        end else if (clear) begin
            byte_cnt <= '0;
            word_idx <= '0;
            ptr      <= ADDR_W'(BASE_ADDR);
        end else if (advance) begin
            if (byte_cnt == LAST) begin
                byte_cnt <= '0;
                word_idx <= word_idx + 1'b1;
                ptr      <= wrap_inc(ptr, ENTRIES);
            end else begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/csr_loader.sv
// Parses a 2-byte length header then streams payload bytes into the sparse word memory (optional trailer check: CSR_LOADER_CHECKSUM_EN).
// wen/writePtr/inData 1 cycle after each accepted payload byte; s_ready depends on state only, never on s_valid.
module csr_loader
    import sparse_pkg::*;
#(
    parameter int ENTRIES        = 64,
    parameter int BASE_ADDR      = 0,
    parameter int BYTES_PER_WORD = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    csr_loader_if.master      bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_written
);

`ifdef CSR_LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_DATA = CHECK;
`else
    localparam loader_state_t AFTER_DATA = DONE;
`endif

    loader_state_t     state, state_nx;
    logic [DATA_W-1:0] len_lo_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] hdr_len;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] word_idx;
    logic              word_complete;
    logic              accept;
    logic              start_acc;
    logic              pay_acc;
    logic              last_word;

    assign bus.s_ready = (state == HDR_LO) || (state == HDR_HI) ||
                         (state == PAYLOAD) || (state == CHECK);
    assign accept      = bus.s_valid && bus.s_ready;
    assign start_acc   = start && (state == IDLE);
    assign pay_acc     = accept && (state == PAYLOAD);
    assign hdr_len     = {bus.s_data, len_lo_q};
    assign last_word   = (word_idx + 1'b1) == len_q;
    assign words_written = word_idx;

    csr_addr_gen #(
        .ENTRIES        (ENTRIES),
        .BASE_ADDR      (BASE_ADDR),
        .BYTES_PER_WORD (BYTES_PER_WORD)
    ) u_addr_gen (
        .clk           (clk),
        .reset         (reset),
        .clear         (start_acc),
        .advance       (pay_acc),
        .ptr           (ptr),
        .word_idx      (word_idx),
        .word_complete (word_complete)
    );

`ifdef CSR_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] xor_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xor_q <= '0;
        end else if (start_acc) begin
            xor_q <= '0;
        end else if (pay_acc) begin
            xor_q <= xor_q ^ bus.s_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = HDR_LO;
            HDR_LO:  if (accept) state_nx = HDR_HI;
            HDR_HI: begin
                if (accept) begin
                    if (hdr_len == '0)                       state_nx = AFTER_DATA;
                    else if (hdr_len > ADDR_W'(ENTRIES))     state_nx = ERR;
                    else                                     state_nx = PAYLOAD;
                end
            end
            PAYLOAD: if (word_complete && last_word) state_nx = AFTER_DATA;
`ifdef CSR_LOADER_CHECKSUM_EN
            CHECK:   if (accept) state_nx = (bus.s_data == xor_q) ? DONE : ERR;
`endif
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs are registered, so done/error land the cycle after the final wen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.wen      <= 1'b0;
            bus.writePtr <= '0;
            bus.inData   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            len_lo_q     <= '0;
            len_q        <= '0;
        end else begin
            bus.wen <= pay_acc;
            if (pay_acc) begin
                bus.writePtr <= ptr;
                bus.inData   <= bus.s_data;
            end
            done <= (state == DONE);
            if (start_acc)          error <= 1'b0;
            else if (state == ERR)  error <= 1'b1;
            if (start_acc)                              busy <= 1'b1;
            else if ((state == DONE) || (state == ERR)) busy <= 1'b0;
            if (accept && (state == HDR_LO)) len_lo_q <= bus.s_data;
            if (accept && (state == HDR_HI)) len_q    <= hdr_len;
        end
    end

endmodule

// File: tb/tb_csr_loader.sv
// Bench: two loaders (BASE_ADDR 0 and 63) fed the same byte stream, checked against a transaction model.
module tb_csr_loader;
    import sparse_pkg::*;

    localparam int BPW = 2;
    localparam int ENT = 64;
`ifdef CSR_LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy0, done0, error0, busy1, done1, error1;
    logic [15:0] ww0, ww1;

    csr_loader_if b0 ();
    csr_loader_if b1 ();

    csr_loader #(.ENTRIES(ENT), .BASE_ADDR(0),  .BYTES_PER_WORD(BPW)) u0 (
        .clk(clk), .reset(reset), .start(start), .bus(b0),
        .busy(busy0), .done(done0), .error(error0), .words_written(ww0));
    csr_loader #(.ENTRIES(ENT), .BASE_ADDR(63), .BYTES_PER_WORD(BPW)) u1 (
        .clk(clk), .reset(reset), .start(start), .bus(b1),
        .busy(busy1), .done(done1), .error(error1), .words_written(ww1));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    // What the driver is presenting this cycle, as the model sees it.
    bit          pay_now = 0, last_now = 0, err_now = 0, start_now = 0;
    logic [15:0] ptr0_now = 0, ptr1_now = 0;

    // Model: wen one edge after a payload byte; done/error two edges after the final byte.
    bit          exp_wen, fin_q1, err_q1, exp_done, exp_error, exp_busy;
    logic [7:0]  exp_dat;
    logic [15:0] exp_p0, exp_p1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_wen <= 0; fin_q1 <= 0; err_q1 <= 0; exp_done <= 0;
            exp_error <= 0; exp_busy <= 0; exp_dat <= 0; exp_p0 <= 0; exp_p1 <= 0;
        end else begin
            exp_wen  <= pay_now;
            exp_dat  <= b0.s_data;
            exp_p0   <= ptr0_now;
            exp_p1   <= ptr1_now;
            fin_q1   <= last_now;
            err_q1   <= err_now;
            exp_done <= fin_q1;
            if (start_now)   exp_error <= 0;
            else if (err_q1) exp_error <= 1;
            if (start_now)             exp_busy <= 1;
            else if (fin_q1 || err_q1) exp_busy <= 0;
        end
    end

    logic [23:0] log0[$];
    logic [23:0] log1[$];

    always @(negedge clk) begin
        chk("wen0", b0.wen, exp_wen);
        chk("wen1", b1.wen, exp_wen);
        if (exp_wen) begin
            chk("ptr0", b0.writePtr, exp_p0);
            chk("ptr1", b1.writePtr, exp_p1);
            chk("data0", b0.inData, exp_dat);
            chk("data1", b1.inData, exp_dat);
        end
        if (b0.wen) log0.push_back({b0.writePtr, b0.inData});
        if (b1.wen) log1.push_back({b1.writePtr, b1.inData});
        chk("done0", done0, exp_done);
        chk("done1", done1, exp_done);
        chk("error0", error0, exp_error);
        chk("error1", error1, exp_error);
        chk("busy0", busy0, exp_busy);
        chk("busy1", busy1, exp_busy);
    end

    logic [7:0] pbytes [0:7];
`ifdef CSR_LOADER_CHECKSUM_EN
    logic [7:0] trail;
    bit         use_xor;
`endif

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_start();
        start = 1; start_now = 1;
        @(posedge clk); #1;
        start = 0; start_now = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rdy, input bit pay,
                             input bit last, input bit err, input int pidx);
        b0.s_valid = 1; b1.s_valid = 1; b0.s_data = b; b1.s_data = b;
        pay_now = pay; last_now = last; err_now = err;
        ptr0_now = 16'((pidx / BPW) % ENT);
        ptr1_now = 16'((63 + pidx / BPW) % ENT);
        @(negedge clk);
        chk("s_ready0", b0.s_ready, rdy);
        chk("s_ready1", b1.s_ready, rdy);
        @(posedge clk); #1;
        b0.s_valid = 0; b1.s_valid = 0;
        pay_now = 0; last_now = 0; err_now = 0;
    endtask

    task automatic load_n(input logic [15:0] n, input int stall_at, input int stall_len);
        int nb;
        logic [7:0] x;
        logic [7:0] lo, hi;
        nb = int'(n) * BPW;
        x = 8'h00;
        lo = n[7:0];
        hi = n[15:8];
        do_start();
        send_byte(lo, 1, 0, 0, 0, 0);
        if (int'(n) > ENT) begin
            send_byte(hi, 1, 0, 0, 1, 0);
        end else begin
            send_byte(hi, 1, 0, (nb == 0) && !CHK, 0, 0);
            for (int k = 0; k < nb; k++) begin
                if (k == stall_at) idle(stall_len);
                x = x ^ pbytes[k];
                send_byte(pbytes[k], 1, 1, (k == nb - 1) && !CHK, 0, k);
            end
`ifdef CSR_LOADER_CHECKSUM_EN
            if (use_xor) trail = x;
            send_byte(trail, 1, 0, trail == x, trail != x, 0);
`endif
        end
        idle(4);
    endtask

    task automatic check_log(input string name, input logic [23:0] got[$], input logic [23:0] want[4]);
        chk({name, "_count"}, got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk(name, got[i], want[i]);
    endtask

    logic [23:0] want[4];

    initial begin
        b0.s_valid = 0; b1.s_valid = 0; b0.s_data = 0; b1.s_data = 0;
`ifdef CSR_LOADER_CHECKSUM_EN
        trail = 0; use_xor = 1;
`endif
        #12;
        chk("rst_wen", b0.wen, 0);
        chk("rst_ptr", b1.writePtr, 0);
        chk("rst_ww", ww0, 0);
        chk("rst_rdy", b0.s_ready, 0);
        @(negedge clk); reset = 1;
        @(posedge clk); #1;

        // Basic load
        pbytes[0] = 8'h11; pbytes[1] = 8'h22; pbytes[2] = 8'h33; pbytes[3] = 8'h44;
        log0.delete(); log1.delete();
        load_n(16'd2, -1, 0);
        want[0] = {16'd0, 8'h11}; want[1] = {16'd0, 8'h22};
        want[2] = {16'd1, 8'h33}; want[3] = {16'd1, 8'h44};
        check_log("basic_log0", log0, want);
        chk("basic_ww0", ww0, 2);
        chk("basic_err", error0, 0);

        // Zero length
        log0.delete();
        load_n(16'd0, -1, 0);
        chk("zero_wen_count", log0.size(), 0);
        chk("zero_ww", ww0, 0);

        // Oversize header
        log0.delete();
        load_n(16'd65, -1, 0);
        chk("over_err", error0, 1);
        chk("over_rdy", b0.s_ready, 0);
        chk("over_wen_count", log0.size(), 0);

        // Wrap and stalls; the start also clears the old error
        pbytes[0] = 8'hAA; pbytes[1] = 8'hBB; pbytes[2] = 8'hCC; pbytes[3] = 8'hDD;
        log1.delete();
        do_start();
        chk("start_clears_err", error0, 0);
        send_byte(8'h02, 1, 0, 0, 0, 0);
        send_byte(8'h00, 1, 0, 0, 0, 0);
        send_byte(8'hAA, 1, 1, 0, 0, 0);
        idle(3);
        send_byte(8'hBB, 1, 1, 0, 0, 1);
        send_byte(8'hCC, 1, 1, 0, 0, 2);
        send_byte(8'hDD, 1, 1, !CHK, 0, 3);
`ifdef CSR_LOADER_CHECKSUM_EN
        send_byte(8'h00, 1, 0, 1, 0, 0);
`endif
        idle(4);
        want[0] = {16'd63, 8'hAA}; want[1] = {16'd63, 8'hBB};
        want[2] = {16'd0, 8'hCC};  want[3] = {16'd0, 8'hDD};
        check_log("wrap_log1", log1, want);
        chk("wrap_ww1", ww1, 2);

        // Reset mid-payload
        log0.delete();
        do_start();
        send_byte(8'h03, 1, 0, 0, 0, 0);
        send_byte(8'h00, 1, 0, 0, 0, 0);
        send_byte(8'h55, 1, 1, 0, 0, 0);
        #1 reset = 0;
        #1;
        chk("arst_wen", b0.wen, 0);
        chk("arst_ptr", b1.writePtr, 0);
        chk("arst_data", b0.inData, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_rdy", b0.s_ready, 0);
        chk("arst_ww", ww0, 0);
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        log0.delete();
        send_byte(8'h66, 0, 0, 0, 0, 0);
        send_byte(8'h77, 0, 0, 0, 0, 0);
        idle(3);
        chk("post_rst_wen_count", log0.size(), 0);

        // Recovery after reset
        pbytes[0] = 8'h11; pbytes[1] = 8'h22; pbytes[2] = 8'h33; pbytes[3] = 8'h44;
        log0.delete();
        load_n(16'd2, -1, 0);
        chk("recover_count", log0.size(), 4);

`ifdef CSR_LOADER_CHECKSUM_EN
        use_xor = 0;
        trail = 8'h44;
        log0.delete();
        load_n(16'd2, -1, 0);
        chk("cks_ok_err", error0, 0);
        chk("cks_ok_count", log0.size(), 4);
        trail = 8'h45;
        log0.delete();
        load_n(16'd2, -1, 0);
        chk("cks_bad_err", error0, 1);
        chk("cks_bad_count", log0.size(), 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_loader.md
Name: csr_loader

Overview:
- Upstream feeder for the sparse-matrix word memory.
- Accepts a byte stream of packed sparse-matrix entries (column index + value bytes) over a valid/ready handshake, parses a 2-byte length header, and drives the memory write port.
- Drives `wen`, `writePtr` and `inData` so each memory word is built from `BYTES_PER_WORD` consecutive bytes shifted in at a single address.
- Reports busy/done/error to the controller.

Parameters:
- ENTRIES, 64, number of memory words; writePtr wraps modulo ENTRIES.
- BASE_ADDR, 0, first memory word address written (must be < ENTRIES).
- BYTES_PER_WORD, 2, bytes shifted into one memory word before writePtr advances (1..16).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load when idle.
- s_valid  in  1  upstream byte valid.
- s_data  in  8  upstream byte.
- s_ready  out  1  loader accepts byte this cycle.
- wen  out  1  memory write enable, registered.
- writePtr  out  16  memory word address, registered.
- inData  out  8  byte to memory, registered.
- busy  out  1  high from the cycle after an accepted start until done/error.
- done  out  1  one-cycle pulse: load complete.
- error  out  1  sticky until the next accepted start or reset.
- words_written  out  16  count of complete words written in the current or last load.

Behaviour:
- Reset (reset low, async) sets:
  - all outputs to 0; writePtr = 0;
  - state IDLE; internal counters to 0.
  - Reset mid-load abandons the load; no further wen.
- States and transitions:
  - IDLE: start -> HDR_LO; clears error and words_written.
  - HDR_LO: byte becomes N[7:0] -> HDR_HI.
  - HDR_HI: byte becomes N[15:8], then:
    - N == 0 -> DONE;
    - N > ENTRIES -> ERR;
    - else -> PAYLOAD.
  - PAYLOAD: runs until N words are complete -> DONE (or CHECK when the optional feature is enabled).
  - DONE: done = 1 for exactly one cycle -> IDLE.
  - ERR: error = 1 -> IDLE the next cycle; error stays high.
- s_ready:
  - 1 in HDR_LO, HDR_HI, PAYLOAD (and CHECK);
  - 0 in IDLE, DONE, ERR.
- Handshake:
  - A byte is accepted only when s_valid && s_ready.
  - No combinational path from s_valid to s_ready.
  - Stalls (s_valid low) hold all counters and produce no wen.
- Payload write timing and addressing:
  - Each accepted payload byte gives wen = 1 on the following cycle, with inData = that byte and writePtr = (BASE_ADDR + word_idx) mod ENTRIES. Latency is 1 cycle.
  - wen = 0 in every cycle without an accepted payload byte in the prior cycle.
- Counters:
  - byte_cnt runs 0..BYTES_PER_WORD-1.
  - On an accepted byte with byte_cnt == BYTES_PER_WORD-1: byte_cnt -> 0, word_idx and words_written increment.
  - Wrap example: BASE_ADDR + word_idx == ENTRIES-1 -> next word uses address 0.
- Completion:
  - The byte completing word N-1 causes the transition to DONE.
  - done asserts the cycle after the final wen, so the final wen is never dropped.
- start handling: start is ignored outside IDLE (including while in DONE).
- Header bytes never produce wen.

Optional Feature:
- Macro CSR_LOADER_CHECKSUM_EN.
- Defined:
  - After the last payload byte, the FSM enters CHECK and accepts one trailer byte.
  - The trailer is compared with the running XOR of all payload bytes. Header bytes are excluded; for N == 0 the expected value is 0x00.
  - Match -> DONE; mismatch -> ERR. The payload writes already issued are retained.
  - N == 0 also passes through CHECK.
- Undefined:
  - No CHECK state and no XOR register.
  - The last payload byte goes straight to DONE.

Decomposition:
- Package sparse_pkg:
  - ADDR_W = 16, DATA_W = 8;
  - loader_state_t enum (IDLE, HDR_LO, HDR_HI, PAYLOAD, CHECK, DONE, ERR);
  - shared with the memory and the multiplier control.
- One sub-module, csr_addr_gen:
  - holds byte_cnt and word_idx;
  - produces the wrapped writePtr and a word_complete strobe;
  - inputs: clear, advance.

Test Plan:
- Basic load (BYTES_PER_WORD=2, BASE_ADDR=0):
  - Stimulus: start; stream 02 00 | 11 22 33 44.
  - Response: wen pulses 4 with (ptr, data) = (0,11), (0,22), (1,33), (1,44); done 1 cycle after the last wen; words_written = 2; error = 0.
- Zero length:
  - Stimulus: start; header 00 00.
  - Response: no wen; done pulse; words_written = 0.
- Oversize:
  - Stimulus: start; header 41 00 (N = 65 > 64).
  - Response: error = 1, no wen, s_ready = 0 afterwards.
  - A following start clears error.
- Wrap and stalls (BASE_ADDR=63):
  - Stimulus: N = 2, bytes AA BB CC DD, with s_valid low for 3 cycles mid-word.
  - Response: writes to ptr 63, 63, 0, 0; no wen during the stall.
- Reset mid-payload:
  - Stimulus: assert reset after 1 byte of N = 3.
  - Response: all outputs 0 immediately (async); state IDLE; no wen after release until a new start.
- CSR_LOADER_CHECKSUM_EN:
  - Stimulus: payload 11 22 33 44, trailer 44.
  - Response: done.
  - Stimulus: same payload, trailer 45.
  - Response: error, with 4 writes already issued.
